// File: rtl/ifetch_line_unit_pkg.sv
// Shared constants and types for the single-line instruction fetch unit.
`default_nettype none

package ifetch_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 32 * LINE_WORDS;
  localparam int WORD_LSB   = 2;
  localparam int TAG_LSB    = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'b0;

endpackage

`default_nettype wire

// File: rtl/ifetch_line_unit_if.sv
// Line-refill bus between the fetch unit (master) and instruction memory (slave).
`default_nettype none

interface ifetch_line_unit_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );

endinterface

`default_nettype wire

// File: rtl/ifetch_line_unit_line_buf.sv
// One-entry line store: valid/tag/data registers, hit compare and word select.
`default_nettype none

module ifetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int TAG_W   = 28,
  parameter int IDX_W   = 2,
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 4
) (
  input  wire logic                            clk_i,
  input  wire logic                            rst_i,
  input  wire logic                            i_inv,
  input  wire logic                            i_install,
  input  wire logic [TAG_W-1:0]                i_tag,
  input  wire logic [N_WORDS-1:0][WORD_W-1:0]  i_line,
  input  wire logic [TAG_W-1:0]                i_lookup_tag,
  input  wire logic [IDX_W-1:0]                i_word,
  output logic                                 o_hit,
  output logic [WORD_W-1:0]                    o_word
);

  logic                           r_valid;
  logic [TAG_W-1:0]               r_tag;
  logic [N_WORDS-1:0][WORD_W-1:0] r_line;

  // Invalidate wins over install so a flush on the fill edge discards the line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_line  <= '0;
    end else if (i_inv) begin
      r_valid <= 1'b0;
    end else if (i_install) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_line  <= i_line;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_word = r_line[i_word];

endmodule

`default_nettype wire

// File: rtl/ifetch_line_unit.sv
// IF-stage fetch front end: single-cycle hits from one line, req/ack refill on miss.
`default_nettype none

module ifetch_line_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = ifetch_pkg::LINE_WORDS
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic              start_i,
  input  wire logic [ADDR_W-1:0] pc_i,
  input  wire logic              flush_i,
  output logic [WORD_W-1:0]      instr_o,
  output logic                   ready_o,
  ifetch_line_unit_if.master     mem
);

  localparam int IDX_W = TAG_LSB - WORD_LSB;
  localparam int TAG_W = ADDR_W - TAG_LSB;

  state_t            r_state;
  logic              r_drop;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_word;
  logic              w_buf_hit;
  logic [WORD_W-1:0] w_buf_word;
  logic              w_hit;
  logic              w_install;
  logic              w_unused_offset;

  assign w_tag           = pc_i[ADDR_W-1:TAG_LSB];
  assign w_word          = pc_i[TAG_LSB-1:WORD_LSB];
  assign w_unused_offset = ^pc_i[WORD_LSB-1:0];

  // A line returning after a flush (earlier in WAIT or on this edge) is never kept.
  assign w_install = (r_state == WAIT) && mem.mem_ack_i && !r_drop && !flush_i;

  ifetch_line_buf #(
    .TAG_W   (TAG_W),
    .IDX_W   (IDX_W),
    .WORD_W  (WORD_W),
    .N_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_inv        (flush_i),
    .i_install    (w_install),
    .i_tag        (r_addr[ADDR_W-1:TAG_LSB]),
    .i_line       (mem.mem_data_i),
    .i_lookup_tag (w_tag),
    .i_word       (w_word),
    .o_hit        (w_buf_hit),
    .o_word       (w_buf_word)
  );

  assign w_hit   = start_i && !flush_i && (r_state == IDLE) && w_buf_hit;
  assign ready_o = w_hit;
  assign instr_o = w_hit ? w_buf_word : WORD_W'(NOP);

  assign mem.mem_req_o  = r_req;
  assign mem.mem_addr_o = r_addr;

  // Once issued, a request is held until its ack regardless of pc/start/flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i && !flush_i && !w_buf_hit) begin
            r_req   <= 1'b1;
            r_addr  <= {w_tag, {TAG_LSB{1'b0}}};
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (mem.mem_ack_i) begin
            r_req   <= 1'b0;
            r_drop  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_line_unit.sv
// Directed bench for ifetch_line_unit; the bench itself plays the instruction memory.
`default_nettype none

module tb_ifetch_line_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        ready;

  int n_vec;
  int n_err;

  localparam logic [127:0] L0  = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] L1  = {32'h54, 32'h53, 32'h52, 32'h51};
  localparam logic [127:0] L2  = {32'h64, 32'h63, 32'h62, 32'h61};
  localparam logic [127:0] L2B = {32'h94, 32'h93, 32'h92, 32'h91};
  localparam logic [127:0] L3  = {32'h74, 32'h73, 32'h72, 32'h71};
  localparam logic [127:0] L4  = {32'h84, 32'h83, 32'h82, 32'h81};

  ifetch_line_unit_if mem_if ();

  ifetch_line_unit dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .pc_i    (pc),
    .flush_i (flush),
    .instr_o (instr),
    .ready_o (ready),
    .mem     (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; pc = 32'h0; flush = 1'b0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_data_i = '0;
    #12;
    n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0b exp=0", mem_if.mem_req_o); end
    n_vec++; if (mem_if.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", mem_if.mem_addr_o); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%0b exp=0", ready); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", instr); end
    start = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_first_fill();
    logic [31:0] exp_w [4];
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    start = 1'b1; pc = 32'h0;
    #1;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL fill_miss_ready got=%0b exp=0", ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (mem_if.mem_req_o !== 1'b1) begin n_err++; $display("FAIL fill_req[%0d] got=%0b exp=1", i, mem_if.mem_req_o); end
      n_vec++; if (mem_if.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL fill_addr[%0d] got=%h exp=0", i, mem_if.mem_addr_o); end
      n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL fill_stall[%0d] got=%0b/%h exp=0/0", i, ready, instr); end
      if (i < 2) tick();
    end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L0;
    tick();
    mem_if.mem_ack_i = 1'b0; mem_if.mem_data_i = '0;
    n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fill_req_drop got=%0b exp=0", mem_if.mem_req_o); end
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      #1;
      n_vec++; if (ready !== 1'b1 || instr !== exp_w[k]) begin n_err++; $display("FAIL fill_hit[%0d] got=%0b/%h exp=1/%h", k, ready, instr, exp_w[k]); end
      tick();
      n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fill_hit_noreq[%0d] got=%0b exp=0", k, mem_if.mem_req_o); end
    end
  endtask

  task automatic test_miss();
    pc = 32'h10;
    #1;
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL miss_nop got=%0b/%h exp=0/0", ready, instr); end
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h10) begin n_err++; $display("FAIL miss_req got=%0b/%h exp=1/10", mem_if.mem_req_o, mem_if.mem_addr_o); end
    tick();
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL miss_wait got=%0b/%h exp=0/0", ready, instr); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L1;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h51) begin n_err++; $display("FAIL miss_hit got=%0b/%h exp=1/51", ready, instr); end
    pc = 32'h1C;
    #1;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h54) begin n_err++; $display("FAIL miss_hit_w3 got=%0b/%h exp=1/54", ready, instr); end
  endtask

  task automatic test_flush_wait();
    pc = 32'h20;
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h20) begin n_err++; $display("FAIL fw_req got=%0b/%h exp=1/20", mem_if.mem_req_o, mem_if.mem_addr_o); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h20) begin n_err++; $display("FAIL fw_hold got=%0b/%h exp=1/20", mem_if.mem_req_o, mem_if.mem_addr_o); end
    tick();
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L2;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fw_ack_req got=%0b exp=0", mem_if.mem_req_o); end
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL fw_discard got=%0b/%h exp=0/0", ready, instr); end
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h20) begin n_err++; $display("FAIL fw_rereq got=%0b/%h exp=1/20", mem_if.mem_req_o, mem_if.mem_addr_o); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL fw_rewait got=%0b exp=0", ready); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L2B;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h91) begin n_err++; $display("FAIL fw_hit got=%0b/%h exp=1/91", ready, instr); end
  endtask

  task automatic test_redirect();
    pc = 32'h10;
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h10) begin n_err++; $display("FAIL rd_req got=%0b/%h exp=1/10", mem_if.mem_req_o, mem_if.mem_addr_o); end
    pc = 32'h40;
    tick();
    n_vec++; if (mem_if.mem_addr_o !== 32'h10 || ready !== 1'b0) begin n_err++; $display("FAIL rd_hold got=%h/%0b exp=10/0", mem_if.mem_addr_o, ready); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L3;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b0 || mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rd_newpc_miss got=%0b/%0b exp=0/0", ready, mem_if.mem_req_o); end
    pc = 32'h14;
    #1;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h72) begin n_err++; $display("FAIL rd_old_installed got=%0b/%h exp=1/72", ready, instr); end
    pc = 32'h40;
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h40) begin n_err++; $display("FAIL rd_req40 got=%0b/%h exp=1/40", mem_if.mem_req_o, mem_if.mem_addr_o); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L4;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h81) begin n_err++; $display("FAIL rd_hit40 got=%0b/%h exp=1/81", ready, instr); end
  endtask

  task automatic test_reset_mid_wait();
    pc = 32'h80;
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1) begin n_err++; $display("FAIL rw_req got=%0b exp=1", mem_if.mem_req_o); end
    rst_n = 1'b0;
    pc = 32'h40;
    #1;
    n_vec++; if (mem_if.mem_req_o !== 1'b0 || mem_if.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rw_async_req got=%0b/%h exp=0/0", mem_if.mem_req_o, mem_if.mem_addr_o); end
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL rw_async_valid got=%0b/%h exp=0/0", ready, instr); end
    tick();
    rst_n = 1'b1; start = 1'b0;
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L4;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rw_stray_req got=%0b exp=0", mem_if.mem_req_o); end
    start = 1'b1;
    #1;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rw_stray_ignored got=%0b exp=0", ready); end
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h40) begin n_err++; $display("FAIL rw_rereq got=%0b/%h exp=1/40", mem_if.mem_req_o, mem_if.mem_addr_o); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L4;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h81) begin n_err++; $display("FAIL rw_hit got=%0b/%h exp=1/81", ready, instr); end
  endtask

  task automatic test_start_low();
    start = 1'b0; pc = 32'h44;
    #1;
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL sl_out got=%0b/%h exp=0/0", ready, instr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (mem_if.mem_req_o !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL sl_idle[%0d] got=%0b/%0b exp=0/0", i, mem_if.mem_req_o, ready); end
    end
    start = 1'b1;
    #1;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h82) begin n_err++; $display("FAIL sl_resume got=%0b/%h exp=1/82", ready, instr); end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    #1;
    n_vec++; if (ready !== 1'b0 || instr !== 32'h0) begin n_err++; $display("FAIL fi_out got=%0b/%h exp=0/0", ready, instr); end
    tick();
    flush = 1'b0;
    n_vec++; if (mem_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fi_noreq got=%0b exp=0", mem_if.mem_req_o); end
    #1;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL fi_invalid got=%0b exp=0", ready); end
    tick();
    n_vec++; if (mem_if.mem_req_o !== 1'b1 || mem_if.mem_addr_o !== 32'h40) begin n_err++; $display("FAIL fi_req got=%0b/%h exp=1/40", mem_if.mem_req_o, mem_if.mem_addr_o); end
    mem_if.mem_ack_i = 1'b1; mem_if.mem_data_i = L4;
    tick();
    mem_if.mem_ack_i = 1'b0;
    n_vec++; if (ready !== 1'b1 || instr !== 32'h82) begin n_err++; $display("FAIL fi_hit got=%0b/%h exp=1/82", ready, instr); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_first_fill();
    test_miss();
    test_flush_wait();
    test_redirect();
    test_reset_mid_wait();
    test_start_low();
    test_flush_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ifetch_line_unit.md
Name: ifetch_line_unit

Overview:
- Instruction-fetch front end that consumes the fetch address driven by the program counter register and returns the instruction word.
- Holds one 4-word instruction line and refills it from a multi-cycle instruction memory over a req/ack handshake.
- Drives ready_o back to the PC register's hazard input: 1 means proceed, 0 means stall.
- Sits between the PC register and the instruction memory, in the IF stage of the pipelined CPU.

Parameters:
- ADDR_W, 32, fetch address width
- WORD_W, 32, instruction width
- LINE_WORDS, 4, words per line (power of 2); line width LINE_W = WORD_W*LINE_WORDS = 128

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; rst_i is asynchronous, active-low.
- start_i  in  1  CPU run enable; 0 means no fetch activity
- pc_i  in  ADDR_W  fetch address, connected to the PC register output
- flush_i  in  1  invalidate the line buffer (fence / program reload)
- instr_o  out  WORD_W  fetched instruction; 32'b0 (NOP) when not ready
- ready_o  out  1  1 = instr_o valid this cycle and PC may advance; 0 = stall
- mem_req_o  out  1  memory read request, registered
- mem_addr_o  out  ADDR_W  line-aligned read address, registered
- mem_ack_i  in  1  one-cycle pulse: mem_data_i valid
- mem_data_i  in  LINE_W  returned line; word k at bits [32k+31:32k]

Behaviour:
- Address split: offset = pc_i[1:0] (ignored); word = pc_i[3:2]; tag = pc_i[31:4].
- Reset (async, rst_i=0):
  - state=IDLE, valid=0, drop=0, tag_q=0, line_q=0
  - mem_req_o=0, mem_addr_o=0
  - instr_o=0, ready_o=0
- Hit (combinational, same cycle): start_i=1, state=IDLE, valid=1, tag_q==tag.
  - ready_o=1, instr_o=line_q[word].
  - Zero added latency; back-to-back hits every cycle.
- All other cases: ready_o=0, instr_o=0.
- FSM states: IDLE, WAIT.
- IDLE:
  - Miss when start_i=1, flush_i=0, and not a hit. At the clock edge: mem_req_o<=1, mem_addr_o<={tag,4'b0}, state<=WAIT.
  - start_i=0: no request, state stays IDLE.
- WAIT:
  - mem_req_o and mem_addr_o held stable until mem_ack_i=1.
  - On the ack edge:
    - if drop=0: line_q<=mem_data_i, tag_q<=mem_addr_o[31:4], valid<=1
    - always: mem_req_o<=0, drop<=0, state<=IDLE
  - The next cycle re-evaluates hit against the current pc_i.
  - Miss penalty = memory latency + 2 cycles: request, ack, then the hit cycle.
- Request cannot be cancelled: once mem_req_o=1 it stays 1 until ack, even if pc_i, start_i or flush_i change.
- flush_i=1:
  - IDLE: valid<=0; no request is issued that cycle; ready_o=0 that cycle.
  - WAIT: drop<=1, so the returning line is discarded. After ack, valid=0, and the next miss re-requests.
  - flush_i=1 on the ack edge: the line is discarded.
- pc_i changed during WAIT (redirect): the pending line is installed anyway (if drop=0) and is correct for its own address. A hit or miss on the new pc_i is evaluated in IDLE.
- mem_ack_i in IDLE: ignored.
- Reset mid-WAIT: all state clears immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package ifetch_pkg:
  - LINE_WORDS, LINE_W
  - field positions: WORD_LSB=2, TAG_LSB=4
  - state encoding: IDLE=1'b0, WAIT=1'b1
  - NOP constant 32'b0
- One sub-module, ifetch_line_buf:
  - holds valid/tag/line registers
  - combinational hit compare and word mux
  - write port: install/invalidate
- The top level contains the FSM, drop flag and memory-interface registers.

Test Plan:
- Reset release, start_i=1, pc_i=0x00, memory acks 3 cycles after request with line {0x44,0x33,0x22,0x11}:
  - mem_req_o=1 with addr 0x00 until the ack edge
  - ready_o=0 throughout
  - next cycle ready_o=1, instr_o=0x11
  - pc_i=0x04/0x08/0x0C then return 0x22/0x33/0x44 with ready_o=1 each cycle.
- pc_i=0x10 after the line above is loaded -> miss, mem_addr_o=0x10, NOP output and ready_o=0 until refilled.
- flush_i pulsed for 1 cycle in WAIT (ack 2 cycles later) -> line not installed; second request issued for the same address; ready_o=1 only after the second ack.
- pc_i redirected 0x10->0x40 during WAIT -> first ack installs the 0x10 line; then a miss and a request to 0x40; ready_o=1 only with pc_i=0x40 data.
- rst_i=0 asserted mid-WAIT -> mem_req_o, valid and ready_o are 0 immediately (asynchronously); a stray mem_ack_i after reset is ignored.
- start_i=0 with valid line and matching pc_i -> ready_o=0, instr_o=0, no memory requests.
